// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoder definitions: scan-code constants, parser states,
// the queued event record and the scan-code to ASCII translation.
package ps2_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_CAPS    = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic       rpt;
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_evt_t;

  localparam int EVT_W = $bits(ps2_evt_t);

  // Keyboard housekeeping bytes (BAT, ACK, echo, resend, errors) carry no key.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic [7:0] ascii_lookup(input logic [7:0] code,
                                              input logic       shift,
                                              input logic       ctrl,
                                              input logic       caps);
    logic [7:0] letter;
    logic [7:0] res;
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00) begin
      if (ctrl)              res = letter - 8'h60;
      else if (shift ^ caps) res = letter - 8'h20;
      else                   res = letter;
    end else begin
      case (code)
        8'h16: res = shift ? 8'h21 : 8'h31;
        8'h1E: res = shift ? 8'h40 : 8'h32;
        8'h26: res = shift ? 8'h23 : 8'h33;
        8'h25: res = shift ? 8'h24 : 8'h34;
        8'h2E: res = shift ? 8'h25 : 8'h35;
        8'h36: res = shift ? 8'h5E : 8'h36;
        8'h3D: res = shift ? 8'h26 : 8'h37;
        8'h3E: res = shift ? 8'h2A : 8'h38;
        8'h46: res = shift ? 8'h28 : 8'h39;
        8'h45: res = shift ? 8'h29 : 8'h30;
        8'h29: res = 8'h20;
        8'h5A: res = 8'h0D;
        8'h66: res = 8'h08;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot on the same edge.
module ps2_evt_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers define which entries are live,
  // and resetting the array would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: prefix parser, modifier/held-key tracking, ASCII
// translation and a queued key-event stream with valid/ready handshake.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_ext,
  output logic             key_brk,
  output logic             key_rpt,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic [7:0]       held_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             shift_flag,
  output logic             ctrl_flag,
  output logic             alt_flag,
  output logic             caps_lock,
  output logic             overflow
);

  ps2_state_t state_q, state_d;
  logic       evt_fire, evt_brk, evt_ext;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    if (ps2_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_EXT)      state_d = ST_EXT;
          else if (ps2_data == SC_BRK) state_d = ST_BRK;
        end
        ST_EXT:     state_d = (ps2_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    evt_fire = 1'b0;
    evt_brk  = 1'b0;
    evt_ext  = 1'b0;
    if (ps2_valid) begin
      unique case (state_q)
        ST_IDLE:    evt_fire = (ps2_data != SC_EXT) && (ps2_data != SC_BRK) &&
                               !is_ctrl_byte(ps2_data);
        ST_EXT: begin
          evt_fire = (ps2_data != SC_BRK);
          evt_ext  = 1'b1;
        end
        ST_BRK: begin
          evt_fire = 1'b1;
          evt_brk  = 1'b1;
        end
        ST_EXT_BRK: begin
          evt_fire = 1'b1;
          evt_brk  = 1'b1;
          evt_ext  = 1'b1;
        end
        default: evt_fire = 1'b0;
      endcase
    end
  end

  // Key state registers.
  logic             shift_q, ctrl_q, alt_q, caps_q, overflow_q;
  logic             shift_d, ctrl_d, alt_d, caps_d, overflow_d;
  logic             held_valid_q, held_ext_q, held_valid_d, held_ext_d;
  logic [7:0]       held_code_q, held_ascii_q, held_code_d, held_ascii_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

  logic             is_shift, is_ctrl, is_alt, is_mod, is_make, is_rpt;
  logic [7:0]       evt_ascii;
  ps2_evt_t         evt, head;
  logic             fifo_full, fifo_empty, pop;

  assign is_shift  = !evt_ext && ((ps2_data == SC_LSHIFT) || (ps2_data == SC_RSHIFT));
  assign is_ctrl   = (ps2_data == SC_CTRL);
  assign is_alt    = (ps2_data == SC_ALT);
  assign is_mod    = is_shift || is_ctrl || is_alt;
  assign is_make   = evt_fire && !evt_brk;
  assign is_rpt    = is_make && held_valid_q && (held_ext_q == evt_ext) &&
                     (held_code_q == ps2_data);
  assign evt_ascii = (!evt_brk && !evt_ext) ?
                     ascii_lookup(ps2_data, shift_q, ctrl_q, caps_q) : 8'h00;

  assign evt = '{rpt: is_rpt, brk: evt_brk, ext: evt_ext,
                 code: ps2_data, ascii: evt_ascii};

  always_comb begin
    shift_d      = shift_q;
    ctrl_d       = ctrl_q;
    alt_d        = alt_q;
    caps_d       = caps_q;
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    held_ascii_d = held_ascii_q;
    press_cnt_d  = press_cnt_q;
    overflow_d   = overflow_q || (evt_fire && fifo_full && !pop);
    if (evt_fire) begin
      if (is_shift) shift_d = !evt_brk;
      if (is_ctrl)  ctrl_d  = !evt_brk;
      if (is_alt)   alt_d   = !evt_brk;
      if (is_make && !is_rpt) begin
        press_cnt_d = press_cnt_q + 1'b1;
        if (ps2_data == SC_CAPS) caps_d = !caps_q;
      end
      if (is_make && !is_mod) begin
        held_valid_d = 1'b1;
        held_ext_d   = evt_ext;
        held_code_d  = ps2_data;
        held_ascii_d = evt_ascii;
      end else if (evt_brk && held_valid_q && (held_code_q == ps2_data) &&
                   (held_ext_q == evt_ext)) begin
        held_valid_d = 1'b0;
        held_ext_d   = 1'b0;
        held_code_d  = 8'h00;
        held_ascii_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= 1'b0;
      ctrl_q       <= 1'b0;
      alt_q        <= 1'b0;
      caps_q       <= 1'b0;
      overflow_q   <= 1'b0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      held_ascii_q <= 8'h00;
      press_cnt_q  <= '0;
    end else begin
      shift_q      <= shift_d;
      ctrl_q       <= ctrl_d;
      alt_q        <= alt_d;
      caps_q       <= caps_d;
      overflow_q   <= overflow_d;
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      held_ascii_q <= held_ascii_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign pop = key_valid && key_ready;

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_fire),
    .din   (evt),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read zero while empty so stale storage never leaks out.
  assign key_valid  = !fifo_empty;
  assign key_code   = key_valid ? head.code  : 8'h00;
  assign key_ascii  = key_valid ? head.ascii : 8'h00;
  assign key_ext    = key_valid && head.ext;
  assign key_brk    = key_valid && head.brk;
  assign key_rpt    = key_valid && head.rpt;

  assign held_valid = held_valid_q;
  assign held_code  = held_code_q;
  assign held_ascii = held_ascii_q;
  assign press_cnt  = press_cnt_q;
  assign shift_flag = shift_q;
  assign ctrl_flag  = ctrl_q;
  assign alt_flag   = alt_q;
  assign caps_lock  = caps_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: stimulus queues expected events, a negedge monitor pops and
// compares every accepted head event; flags/counters are checked inline.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       ps2_data = 8'h00;
  logic             ps2_valid = 1'b0;
  logic             key_valid, key_ready;
  logic [7:0]       key_code, key_ascii, held_code, held_ascii;
  logic             key_ext, key_brk, key_rpt, held_valid;
  logic [CNT_W-1:0] press_cnt;
  logic             shift_flag, ctrl_flag, alt_flag, caps_lock, overflow;

  int n_vec = 0;
  int n_err = 0;
  ps2_evt_t exp_q[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_ascii(key_ascii), .key_ext(key_ext), .key_brk(key_brk),
    .key_rpt(key_rpt), .held_valid(held_valid), .held_code(held_code),
    .held_ascii(held_ascii), .press_cnt(press_cnt), .shift_flag(shift_flag),
    .ctrl_flag(ctrl_flag), .alt_flag(alt_flag), .caps_lock(caps_lock),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares the head event on every accepting cycle.
  always @(negedge clk) begin
    ps2_evt_t got, want;
    if (!rst && key_valid && key_ready) begin
      got = '{rpt: key_rpt, brk: key_brk, ext: key_ext, code: key_code, ascii: key_ascii};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL evt_unexpected: got %05h with nothing expected", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL evt_compare: got %05h expected %05h", got, want);
        end
      end
    end
  end

  task automatic push_exp(input logic rpt, input logic brk, input logic ext,
                          input logic [7:0] code, input logic [7:0] ascii);
    exp_q.push_back('{rpt: rpt, brk: brk, ext: ext, code: code, ascii: ascii});
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is consumed.
  task automatic send(input logic [7:0] b);
    ps2_data  = b;
    ps2_valid = 1'b1;
    @(posedge clk); #1;
    ps2_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || key_valid); i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    key_ready = 1'b1;
    do_reset();

    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_fields", {key_ascii, key_ext, key_brk, key_rpt}, 0);
    check("rst_held", {held_valid, held_code, held_ascii}, 0);
    check("rst_press_cnt", press_cnt, 0);
    check("rst_flags", {shift_flag, ctrl_flag, alt_flag, caps_lock, overflow}, 0);

    // Plain letter make/break.
    push_exp(0, 0, 0, 8'h1C, 8'h61); send(8'h1C);
    check("t1_held_valid", held_valid, 1);
    check("t1_held", {held_code, held_ascii}, 16'h1C61);
    send(8'hF0);
    push_exp(0, 1, 0, 8'h1C, 8'h00); send(8'h1C);
    check("t1_held_clear", held_valid, 0);
    check("t1_press_cnt", press_cnt, 1);

    // Shifted letter.
    push_exp(0, 0, 0, 8'h12, 8'h00); send(8'h12);
    check("t2_shift_on", shift_flag, 1);
    push_exp(0, 0, 0, 8'h1C, 8'h41); send(8'h1C);
    send(8'hF0); push_exp(0, 1, 0, 8'h1C, 8'h00); send(8'h1C);
    check("t2_shift_held", shift_flag, 1);
    send(8'hF0); push_exp(0, 1, 0, 8'h12, 8'h00); send(8'h12);
    check("t2_shift_off", shift_flag, 0);
    check("t2_press_cnt", press_cnt, 3);

    // Caps lock, then shift cancels caps; second 1C make is a repeat.
    push_exp(0, 0, 0, 8'h58, 8'h00); send(8'h58);
    check("t3_caps_on", caps_lock, 1);
    send(8'hF0); push_exp(0, 1, 0, 8'h58, 8'h00); send(8'h58);
    check("t3_caps_kept", caps_lock, 1);
    push_exp(0, 0, 0, 8'h1C, 8'h41); send(8'h1C);
    push_exp(0, 0, 0, 8'h12, 8'h00); send(8'h12);
    push_exp(1, 0, 0, 8'h1C, 8'h61); send(8'h1C);
    check("t3_press_cnt", press_cnt, 6);
    send(8'hF0); push_exp(0, 1, 0, 8'h1C, 8'h00); send(8'h1C);
    send(8'hF0); push_exp(0, 1, 0, 8'h12, 8'h00); send(8'h12);

    // Extended key with typematic repeat.
    send(8'hE0); push_exp(0, 0, 1, 8'h75, 8'h00); send(8'h75);
    check("t4_held_ext", {held_valid, held_code}, 9'h175);
    send(8'hE0); push_exp(1, 0, 1, 8'h75, 8'h00); send(8'h75);
    send(8'hE0); send(8'hF0); push_exp(0, 1, 1, 8'h75, 8'h00); send(8'h75);
    check("t4_press_cnt", press_cnt, 7);
    check("t4_held_clear", held_valid, 0);

    // Right ctrl (extended) produces control characters.
    send(8'hE0); push_exp(0, 0, 1, 8'h14, 8'h00); send(8'h14);
    check("t5_ctrl_on", ctrl_flag, 1);
    push_exp(0, 0, 0, 8'h21, 8'h03); send(8'h21);
    send(8'hF0); push_exp(0, 1, 0, 8'h21, 8'h00); send(8'h21);
    send(8'hE0); send(8'hF0); push_exp(0, 1, 1, 8'h14, 8'h00); send(8'h14);
    check("t5_ctrl_off", ctrl_flag, 0);

    // Digits, space, dropped housekeeping byte, alt.
    push_exp(0, 0, 0, 8'h59, 8'h00); send(8'h59);
    push_exp(0, 0, 0, 8'h16, 8'h21); send(8'h16);
    send(8'hF0); push_exp(0, 1, 0, 8'h16, 8'h00); send(8'h16);
    send(8'hF0); push_exp(0, 1, 0, 8'h59, 8'h00); send(8'h59);
    push_exp(0, 0, 0, 8'h45, 8'h30); send(8'h45);
    send(8'hF0); push_exp(0, 1, 0, 8'h45, 8'h00); send(8'h45);
    push_exp(0, 0, 0, 8'h29, 8'h20); send(8'h29);
    send(8'hF0); push_exp(0, 1, 0, 8'h29, 8'h00); send(8'h29);
    send(8'hAA);
    check("t6_press_cnt_drop", press_cnt, 13);
    push_exp(0, 0, 0, 8'h11, 8'h00); send(8'h11);
    check("t6_alt_on", alt_flag, 1);
    send(8'hF0); push_exp(0, 1, 0, 8'h11, 8'h00); send(8'h11);
    check("t6_alt_off", alt_flag, 0);
    check("t6_press_cnt", press_cnt, 14);
    drain();

    // Overflow: 9 makes with consumer stalled, 9th dropped.
    do_reset();
    key_ready = 1'b0;
    begin
      logic [7:0] codes [9];
      logic [7:0] asc   [9];
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      asc   = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
      for (int i = 0; i < 9; i++) begin
        if (i < FIFO_DEPTH) push_exp(0, 0, 0, codes[i], asc[i]);
        send(codes[i]);
      end
    end
    check("t7_key_valid", key_valid, 1);
    check("t7_head_stable", {key_code, key_ascii}, 16'h1C61);
    check("t7_overflow", overflow, 1);
    check("t7_press_cnt", press_cnt, 9);
    // Full FIFO with a pop on the same edge accepts the push.
    key_ready = 1'b1;
    push_exp(0, 0, 0, 8'h3B, 8'h6A); send(8'h3B);
    drain();
    check("t7_overflow_sticky", overflow, 1);
    check("t7_press_cnt_end", press_cnt, 10);

    // Reset mid-sequence discards the F0 prefix.
    send(8'hF0);
    do_reset();
    push_exp(0, 0, 0, 8'h1C, 8'h61); send(8'h1C);
    check("t8_press_cnt", press_cnt, 1);
    check("t8_overflow_clr", overflow, 0);
    drain();
    check("end_key_valid", key_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
